// File: rtl/rf_arb_pkg.sv
// Shared constants and types for the register-file write arbiter.
// Included by rf_write_arbiter and rf_scoreboard.
package rf_arb_pkg;

  localparam int RF_DATA_W = 32;
  localparam int RF_ADDR_W = 5;
  localparam int RF_NREGS  = 32;

  typedef struct packed {
    logic [RF_ADDR_W-1:0] rd;
    logic [RF_DATA_W-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-write bitmap: one bit per architectural register.
// Set has priority over clear; x0 is never marked busy.
module rf_scoreboard
  import rf_arb_pkg::*;
#(
  parameter int ADDR_W = RF_ADDR_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 set_en,
  input  logic [ADDR_W-1:0]    set_idx,
  input  logic                 clr_en,
  input  logic [ADDR_W-1:0]    clr_idx,
  output logic [RF_NREGS-1:0]  busy
);

  logic [RF_NREGS-1:0] set_mask;
  logic [RF_NREGS-1:0] clr_mask;
  logic [RF_NREGS-1:0] busy_nxt;

  // Build set/clear masks and merge them, set winning on collision
  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (set_en && set_idx != '0)
      set_mask[set_idx] = 1'b1;
    if (clr_en && clr_idx != '0)
      clr_mask[clr_idx] = 1'b1;
    busy_nxt    = (busy & ~clr_mask) | set_mask;
    busy_nxt[0] = 1'b0;
  end

  // Bitmap register, cleared by reset
  always_ff @(posedge clk) begin
    if (rst)
      busy <= '0;
    else
      busy <= busy_nxt;
  end

endmodule

// File: rtl/rf_write_arbiter.sv
// Round-robin arbiter sharing the RF write port between ALU and load unit.
// Define RF_ARB_SCOREBOARD_EN to build the pending-write scoreboard.
module rf_write_arbiter
  import rf_arb_pkg::*;
#(
  parameter int DATA_W = RF_DATA_W,
  parameter int ADDR_W = RF_ADDR_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wb0_valid,
  input  logic [ADDR_W-1:0]   wb0_rd,
  input  logic [DATA_W-1:0]   wb0_data,
  output logic                wb0_ready,
  input  logic                wb1_valid,
  input  logic [ADDR_W-1:0]   wb1_rd,
  input  logic [DATA_W-1:0]   wb1_data,
  output logic                wb1_ready,
  input  logic                hold,
  input  logic                rsv_en,
  input  logic [ADDR_W-1:0]   rsv_rd,
  output logic                Ruwr,
  output logic [ADDR_W-1:0]   rd,
  output logic [DATA_W-1:0]   datawrite,
  output logic [RF_NREGS-1:0] busy
);

  typedef struct packed {
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
  } req_t;

  // last = port granted most recently; the other port wins a tie
  logic last;
  logic open;
  logic xfer;
  logic wen;
  req_t win;

  assign open = !rst && !hold;

  assign wb0_ready = open && wb0_valid
                  && (!wb1_valid || last);
  assign wb1_ready = open && wb1_valid
                  && (!wb0_valid || !last);

  // Select the granted request and decide if it reaches the RF
  always_comb begin
    xfer = wb0_ready || wb1_ready;
    if (wb0_ready)
      win = '{rd: wb0_rd, data: wb0_data};
    else
      win = '{rd: wb1_rd, data: wb1_data};
    wen = xfer && (win.rd != '0);
  end

  // Round-robin pointer, moves only on a transfer
  always_ff @(posedge clk) begin
    if (rst)
      last <= 1'b1;
    else if (xfer)
      last <= wb1_ready;
  end

  // Registered write triple toward the register file
  always_ff @(posedge clk) begin
    if (rst) begin
      Ruwr      <= 1'b0;
      rd        <= '0;
      datawrite <= '0;
    end else begin
      Ruwr <= wen;
      if (xfer) begin
        rd        <= win.rd;
        datawrite <= win.data;
      end
    end
  end

`ifdef RF_ARB_SCOREBOARD_EN
  rf_scoreboard #(
    .ADDR_W (ADDR_W)
  ) u_sb (
    .clk     (clk),
    .rst     (rst),
    .set_en  (rsv_en),
    .set_idx (rsv_rd),
    .clr_en  (wen),
    .clr_idx (win.rd),
    .busy    (busy)
  );
`else
  logic unused_rsv;
  assign unused_rsv = ^{rsv_en, rsv_rd};
  assign busy = '0;
`endif

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed-vector bench for rf_write_arbiter.
// Busy expectations follow RF_ARB_SCOREBOARD_EN.
module tb_rf_write_arbiter;

`ifdef RF_ARB_SCOREBOARD_EN
  localparam bit SB = 1'b1;
`else
  localparam bit SB = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        wb0_valid, wb1_valid;
  logic [4:0]  wb0_rd, wb1_rd;
  logic [31:0] wb0_data, wb1_data;
  logic        wb0_ready, wb1_ready;
  logic        hold, rsv_en;
  logic [4:0]  rsv_rd;
  logic        Ruwr;
  logic [4:0]  rd;
  logic [31:0] datawrite;
  logic [31:0] busy;

  int vecs = 0;
  int errs = 0;

  rf_write_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .wb0_valid (wb0_valid),
    .wb0_rd    (wb0_rd),
    .wb0_data  (wb0_data),
    .wb0_ready (wb0_ready),
    .wb1_valid (wb1_valid),
    .wb1_rd    (wb1_rd),
    .wb1_data  (wb1_data),
    .wb1_ready (wb1_ready),
    .hold      (hold),
    .rsv_en    (rsv_en),
    .rsv_rd    (rsv_rd),
    .Ruwr      (Ruwr),
    .rd        (rd),
    .datawrite (datawrite),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of inputs (just after negedge), check readys,
  // then advance to the next negedge.
  task automatic cyc(input string tag,
                     input logic v0, input logic [4:0] a0,
                     input logic [31:0] d0,
                     input logic v1, input logic [4:0] a1,
                     input logic [31:0] d1,
                     input logic h, input logic re,
                     input logic [4:0] ra,
                     input logic e0, input logic e1);
    wb0_valid = v0; wb0_rd = a0; wb0_data = d0;
    wb1_valid = v1; wb1_rd = a1; wb1_data = d1;
    hold = h; rsv_en = re; rsv_rd = ra;
    #1;
    chk({tag, "_rdy0"}, {31'd0, wb0_ready}, {31'd0, e0});
    chk({tag, "_rdy1"}, {31'd0, wb1_ready}, {31'd0, e1});
    @(negedge clk);
  endtask

  task automatic wr(input string tag, input logic er,
                    input logic [4:0] erd,
                    input logic [31:0] ed);
    chk({tag, "_ruwr"}, {31'd0, Ruwr}, {31'd0, er});
    if (er) begin
      chk({tag, "_rd"}, {27'd0, rd}, {27'd0, erd});
      chk({tag, "_data"}, datawrite, ed);
    end
  endtask

  task automatic bz(input string tag, input logic [31:0] e);
    chk({tag, "_busy"}, busy, SB ? e : 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    wb0_valid = 0; wb0_rd = 0; wb0_data = 0;
    wb1_valid = 0; wb1_rd = 0; wb1_data = 0;
    hold = 0; rsv_en = 0; rsv_rd = 0;
    repeat (2) @(negedge clk);

    // reset cycle: readys blocked, outputs at reset values
    cyc("rst", 1, 5'd1, 32'h11, 1, 5'd2, 32'h22,
        0, 1, 5'd4, 0, 0);
    wr("rst", 0, 0, 0);
    chk("rst_rd", {27'd0, rd}, 32'd0);
    chk("rst_data", datawrite, 32'd0);
    bz("rst", 32'd0);
    rst = 1'b0;

    // contention: alternate 0,1,0,1 starting at port 0
    cyc("c1", 1, 5'd1, 32'hA000_0001, 1, 5'd2, 32'hB000_0002,
        0, 0, 0, 1, 0);
    wr("c1", 1, 5'd1, 32'hA000_0001);
    cyc("c2", 1, 5'd3, 32'hA000_0003, 1, 5'd2, 32'hB000_0002,
        0, 0, 0, 0, 1);
    wr("c2", 1, 5'd2, 32'hB000_0002);
    cyc("c3", 1, 5'd3, 32'hA000_0003, 1, 5'd4, 32'hB000_0004,
        0, 0, 0, 1, 0);
    wr("c3", 1, 5'd3, 32'hA000_0003);
    cyc("c4", 1, 5'd5, 32'hA000_0005, 1, 5'd4, 32'hB000_0004,
        0, 0, 0, 0, 1);
    wr("c4", 1, 5'd4, 32'hB000_0004);
    cyc("i1", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    wr("i1", 0, 0, 0);

    // single requester on port 1
    cyc("s1", 0, 0, 0, 1, 5'd7, 32'hDEAD_BEEF,
        0, 0, 0, 0, 1);
    wr("s1", 1, 5'd7, 32'hDEAD_BEEF);
    cyc("s2", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    wr("s2", 0, 0, 0);

    // hold blocks everything, pointer (=1) unchanged
    for (int i = 0; i < 3; i++) begin
      cyc("hold", 1, 5'd0, 32'h55, 1, 5'd9, 32'h99,
          1, 0, 0, 0, 0);
      wr("hold", 0, 0, 0);
    end

    // release: port 0 wins with rd=0, no RF write
    cyc("x0", 1, 5'd0, 32'h55, 1, 5'd9, 32'h99,
        0, 0, 0, 1, 0);
    wr("x0", 0, 0, 0);
    cyc("x0b", 1, 5'd10, 32'hAA, 1, 5'd9, 32'h99,
        0, 0, 0, 0, 1);
    wr("x0b", 1, 5'd9, 32'h99);
    cyc("i2", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    wr("i2", 0, 0, 0);

    // scoreboard set / set-wins / clear / x0 ignored
    cyc("sb1", 0, 0, 0, 0, 0, 0, 0, 1, 5'd5, 0, 0);
    bz("sb1", 32'h20);
    cyc("sb2", 1, 5'd5, 32'h1234, 0, 0, 0,
        0, 1, 5'd5, 1, 0);
    wr("sb2", 1, 5'd5, 32'h1234);
    bz("sb2", 32'h20);
    cyc("sb3", 1, 5'd5, 32'h5678, 0, 0, 0,
        0, 0, 0, 1, 0);
    wr("sb3", 1, 5'd5, 32'h5678);
    bz("sb3", 32'h0);
    cyc("sb4", 0, 0, 0, 0, 0, 0, 0, 1, 5'd0, 0, 0);
    wr("sb4", 0, 0, 0);
    bz("sb4", 32'h0);
    cyc("sb5", 0, 0, 0, 0, 0, 0, 0, 1, 5'd3, 0, 0);
    bz("sb5", 32'h8);

    // grant then reset: in-flight write squashed, busy cleared
    cyc("r1", 0, 0, 0, 1, 5'd12, 32'hCAFE,
        0, 1, 5'd6, 0, 1);
    wr("r1", 1, 5'd12, 32'hCAFE);
    bz("r1", 32'h48);
    rst = 1'b1;
    cyc("r2", 1, 5'd1, 32'h1, 1, 5'd2, 32'h2,
        0, 1, 5'd7, 0, 0);
    wr("r2", 0, 0, 0);
    chk("r2_rd", {27'd0, rd}, 32'd0);
    chk("r2_data", datawrite, 32'd0);
    bz("r2", 32'h0);
    rst = 1'b0;

    // pointer back to reset value: port 0 wins
    cyc("r3", 1, 5'd1, 32'h1, 1, 5'd2, 32'h2,
        0, 0, 0, 1, 0);
    wr("r3", 1, 5'd1, 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==",
             vecs, errs);
    $finish;
  end

endmodule
